// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble control zeroing.
// Optional stall counter output when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
  parameter int PC_W     = 32,
  parameter int CTRL_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W*NUM_DATA-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W*NUM_DATA-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int DW = DATA_W * NUM_DATA;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                in_ready_q, out_valid_q;
  logic                in_fire, out_fire;
  logic                load_main_in, load_main_skid, load_skid, clear_ctrl;
  logic [PC_W-1:0]     main_pc, skid_pc;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic [DW-1:0]       main_data, skid_data;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_pc;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and register load selection.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_ctrl     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end else begin
          state_next = EMPTY;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          clear_ctrl = 1'b1;
          state_next = EMPTY;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else begin
          state_next = ONE;
        end
      end
      TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end else begin
          state_next = TWO;
        end
      end
      default: begin
        clear_ctrl = 1'b1;
        state_next = EMPTY;
      end
    endcase
  end

  // State register; ready/valid are registered from the next state so neither has a comb input path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next != TWO);
      out_valid_q <= (state_next != EMPTY);
    end
  end

  // Head and skid storage; control is zeroed whenever the head becomes a bubble, pc/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_pc   <= '0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_pc   <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_pc   <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_pc   <= in_pc;
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clear_ctrl) begin
        main_ctrl <= '0;
      end else begin
        main_ctrl <= main_ctrl;
      end
      if (load_skid) begin
        skid_pc   <= in_pc;
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else begin
        skid_pc <= skid_pc;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where the head is blocked by downstream; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
